// File: rtl/pio_pkg.sv
// pio_pkg: shared PIO constants, CC descriptor layout, FSM encodings and completion helpers
package pio_pkg;

    localparam int CC_LA_LSB   = 0;
    localparam int CC_AT_LSB   = 8;
    localparam int CC_BC_LSB   = 16;
    localparam int CC_DWC_LSB  = 32;
    localparam int CC_STAT_LSB = 43;
    localparam int CC_RID_LSB  = 48;
    localparam int CC_TAG_LSB  = 64;
    localparam int CC_TC_LSB   = 89;
    localparam int CC_ATTR_LSB = 92;
    localparam int CC_DATA_LSB = 96;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;

    typedef enum logic {IDLE, SEND} tx_state_t;

    typedef struct packed {
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [1:0]  at;
        logic [31:0] data;
    } cc_req_t;

    function automatic logic [6:0] lower_addr(logic [4:0] addr_hi, logic [3:0] be);
        logic [1:0] lo2;
        lo2 = be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : be[3] ? 2'd3 : 2'd0;
        return {addr_hi, lo2};
    endfunction

    function automatic logic [12:0] byte_count(logic [3:0] be);
        return (be[3] & be[0]) ? 13'd4 :
               ((~be[3] & be[2] & be[0]) | (be[3] & be[1] & ~be[0])) ? 13'd3 :
               (be == 4'h3 || be == 4'h6 || be == 4'hC) ? 13'd2 : 13'd1;
    endfunction

endpackage

// File: rtl/pio_tx_slot.sv
// pio_tx_slot: per-BAR read response holding register with valid, clear and sticky overflow
module pio_tx_slot
    import pio_pkg::*;
(
    input  logic    pcie_clk,
    input  logic    pcie_rst_n,
    input  logic    rd_valid,
    input  cc_req_t req_in,
    input  logic    clr,
    output logic    valid,
    output cc_req_t req,
    output logic    overflow
);

    logic capture;

    // A clear on the same edge frees the slot, so the new response is taken instead of dropped
    assign capture = rd_valid & (~valid | clr);

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            valid    <= 1'b0;
            req      <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= capture | (valid & ~clr);
            if (capture)
                req <= req_in;
            if (rd_valid & valid & ~clr)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/pio_tx_engine.sv
// pio_tx_engine: completer completion transmitter returning one-DW read data for BAR0/BAR1
module pio_tx_engine
    import pio_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst_n,
    input  logic [2:0]              bar0_req_tc,
    input  logic [2:0]              bar0_req_attr,
    input  logic [10:0]             bar0_req_len,
    input  logic [15:0]             bar0_req_rid,
    input  logic [7:0]              bar0_req_tag,
    input  logic [7:0]              bar0_req_be,
    input  logic [15:0]             bar0_req_addr,
    input  logic [1:0]              bar0_req_at,
    input  logic                    bar0_rd_valid,
    input  logic [31:0]             bar0_rd_data,
    input  logic [2:0]              bar1_req_tc,
    input  logic [2:0]              bar1_req_attr,
    input  logic [10:0]             bar1_req_len,
    input  logic [15:0]             bar1_req_rid,
    input  logic [7:0]              bar1_req_tag,
    input  logic [7:0]              bar1_req_be,
    input  logic [15:0]             bar1_req_addr,
    input  logic [1:0]              bar1_req_at,
    input  logic                    bar1_rd_valid,
    input  logic [31:0]             bar1_rd_data,
    output logic [C_DATA_WIDTH-1:0] s_axis_cc_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_cc_tkeep,
    output logic                    s_axis_cc_tlast,
    output logic                    s_axis_cc_tvalid,
    output logic [32:0]             s_axis_cc_tuser,
    input  logic                    s_axis_cc_tready,
    output logic                    compl_done,
    output logic                    slot_overflow
);

    tx_state_t               state, state_n;
    cc_req_t                 req0_in, req1_in, r0, r1, sel;
    logic                    v0, v1, ovf0, ovf1, clr0, clr1, pick1;
    logic                    gnt, gnt_n, last0, last0_n, tvalid_n, done_n;
    logic [C_DATA_WIDTH-1:0] beat, tdata_n;
    logic                    unused_ok;

    assign req0_in = '{tc: bar0_req_tc, attr: bar0_req_attr, rid: bar0_req_rid, tag: bar0_req_tag,
                       be: bar0_req_be[3:0], addr: bar0_req_addr[6:0], at: bar0_req_at, data: bar0_rd_data};
    assign req1_in = '{tc: bar1_req_tc, attr: bar1_req_attr, rid: bar1_req_rid, tag: bar1_req_tag,
                       be: bar1_req_be[3:0], addr: bar1_req_addr[6:0], at: bar1_req_at, data: bar1_rd_data};

    pio_tx_slot u_slot0 (.pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .rd_valid(bar0_rd_valid),
                         .req_in(req0_in), .clr(clr0), .valid(v0), .req(r0), .overflow(ovf0));
    pio_tx_slot u_slot1 (.pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .rd_valid(bar1_rd_valid),
                         .req_in(req1_in), .clr(clr1), .valid(v1), .req(r1), .overflow(ovf1));

    // Round robin: BAR1 only overtakes when BAR0 holds the most recent grant
    assign pick1 = v1 & (~v0 | last0);

    always_comb begin
        sel = pick1 ? r1 : r0;
        beat = '0;
        beat[CC_LA_LSB +: 7]    = lower_addr(sel.addr[6:2], sel.be);
        beat[CC_AT_LSB +: 2]    = sel.at;
        beat[CC_BC_LSB +: 13]   = byte_count(sel.be);
        beat[CC_DWC_LSB +: 11]  = 11'd1;
        beat[CC_STAT_LSB +: 3]  = CPL_SC;
        beat[CC_RID_LSB +: 16]  = sel.rid;
        beat[CC_TAG_LSB +: 8]   = sel.tag;
        beat[CC_TC_LSB +: 3]    = sel.tc;
        beat[CC_ATTR_LSB +: 3]  = sel.attr;
        beat[CC_DATA_LSB +: 32] = sel.data;
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        last0_n  = last0;
        tvalid_n = s_axis_cc_tvalid;
        tdata_n  = s_axis_cc_tdata;
        done_n   = 1'b0;
        clr0     = 1'b0;
        clr1     = 1'b0;
        case (state)
            IDLE: if (v0 | v1) begin
                gnt_n    = pick1;
                tdata_n  = beat;
                tvalid_n = 1'b1;
                state_n  = SEND;
            end
            SEND: if (s_axis_cc_tready) begin
                tvalid_n = 1'b0;
                done_n   = 1'b1;
                clr0     = ~gnt;
                clr1     = gnt;
                last0_n  = ~gnt;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state            <= IDLE;
            gnt              <= 1'b0;
            last0            <= 1'b0;
            s_axis_cc_tvalid <= 1'b0;
            s_axis_cc_tdata  <= '0;
            compl_done       <= 1'b0;
        end else begin
            state            <= state_n;
            gnt              <= gnt_n;
            last0            <= last0_n;
            s_axis_cc_tvalid <= tvalid_n;
            s_axis_cc_tdata  <= tdata_n;
            compl_done       <= done_n;
        end
    end

    assign s_axis_cc_tkeep = {KEEP_WIDTH{s_axis_cc_tvalid}};
    assign s_axis_cc_tlast = s_axis_cc_tvalid;
    assign s_axis_cc_tuser = '0;
    assign slot_overflow   = ovf0 | ovf1;

    assign unused_ok = ^{bar0_req_len, bar0_req_be[7:4], bar0_req_addr[15:7],
                         bar1_req_len, bar1_req_be[7:4], bar1_req_addr[15:7], sel.addr[1:0]};

endmodule

// File: tb/tb_pio_tx_engine.sv
// tb_pio_tx_engine: scoreboard bench for the PIO completion transmitter
module tb_pio_tx_engine;

    logic         pcie_clk = 1'b0;
    logic         pcie_rst_n = 1'b0;
    logic [2:0]   bar0_req_tc = '0, bar0_req_attr = '0, bar1_req_tc = '0, bar1_req_attr = '0;
    logic [10:0]  bar0_req_len = '0, bar1_req_len = '0;
    logic [15:0]  bar0_req_rid = '0, bar0_req_addr = '0, bar1_req_rid = '0, bar1_req_addr = '0;
    logic [7:0]   bar0_req_tag = '0, bar0_req_be = '0, bar1_req_tag = '0, bar1_req_be = '0;
    logic [1:0]   bar0_req_at = '0, bar1_req_at = '0;
    logic         bar0_rd_valid = 1'b0, bar1_rd_valid = 1'b0;
    logic [31:0]  bar0_rd_data = '0, bar1_rd_data = '0;
    logic [127:0] s_axis_cc_tdata;
    logic [3:0]   s_axis_cc_tkeep;
    logic         s_axis_cc_tlast, s_axis_cc_tvalid, compl_done, slot_overflow;
    logic [32:0]  s_axis_cc_tuser;
    logic         s_axis_cc_tready = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic         prev_acc = 1'b0;
    logic [127:0] exp_q[$];

    pio_tx_engine dut (
        .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
        .bar0_req_tc(bar0_req_tc), .bar0_req_attr(bar0_req_attr), .bar0_req_len(bar0_req_len),
        .bar0_req_rid(bar0_req_rid), .bar0_req_tag(bar0_req_tag), .bar0_req_be(bar0_req_be),
        .bar0_req_addr(bar0_req_addr), .bar0_req_at(bar0_req_at),
        .bar0_rd_valid(bar0_rd_valid), .bar0_rd_data(bar0_rd_data),
        .bar1_req_tc(bar1_req_tc), .bar1_req_attr(bar1_req_attr), .bar1_req_len(bar1_req_len),
        .bar1_req_rid(bar1_req_rid), .bar1_req_tag(bar1_req_tag), .bar1_req_be(bar1_req_be),
        .bar1_req_addr(bar1_req_addr), .bar1_req_at(bar1_req_at),
        .bar1_rd_valid(bar1_rd_valid), .bar1_rd_data(bar1_rd_data),
        .s_axis_cc_tdata(s_axis_cc_tdata), .s_axis_cc_tkeep(s_axis_cc_tkeep),
        .s_axis_cc_tlast(s_axis_cc_tlast), .s_axis_cc_tvalid(s_axis_cc_tvalid),
        .s_axis_cc_tuser(s_axis_cc_tuser), .s_axis_cc_tready(s_axis_cc_tready),
        .compl_done(compl_done), .slot_overflow(slot_overflow)
    );

    always #4 pcie_clk = ~pcie_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Expected beat derived from the first/last enabled byte positions
    function automatic logic [127:0] model(input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [15:0] addr, input logic [7:0] be,
                                           input logic [31:0] data);
        int first, last;
        logic [127:0] d;
        first = 0;
        last = -1;
        for (int i = 3; i >= 0; i--) if (be[i]) first = i;
        for (int i = 0; i < 4; i++) if (be[i]) last = i;
        d = '0;
        d[6:0]    = {addr[6:2], 2'(first)};
        d[9:8]    = tag[7:6];
        d[28:16]  = (last < 0) ? 13'd1 : 13'(last - first + 1);
        d[42:32]  = 11'd1;
        d[63:48]  = rid;
        d[71:64]  = tag;
        d[91:89]  = tag[2:0];
        d[94:92]  = tag[5:3];
        d[127:96] = data;
        return d;
    endfunction

    task automatic set_req(input bit bar, input logic [15:0] rid, input logic [7:0] tag,
                           input logic [15:0] addr, input logic [7:0] be, input logic [31:0] data,
                           input bit expect_cpl);
        if (!bar) begin
            bar0_req_tc = tag[2:0]; bar0_req_attr = tag[5:3]; bar0_req_at = tag[7:6];
            bar0_req_len = 11'd3; bar0_req_rid = rid; bar0_req_tag = tag; bar0_req_addr = addr;
            bar0_req_be = be; bar0_rd_data = data; bar0_rd_valid = 1'b1;
        end else begin
            bar1_req_tc = tag[2:0]; bar1_req_attr = tag[5:3]; bar1_req_at = tag[7:6];
            bar1_req_len = 11'd3; bar1_req_rid = rid; bar1_req_tag = tag; bar1_req_addr = addr;
            bar1_req_be = be; bar1_rd_data = data; bar1_rd_valid = 1'b1;
        end
        if (expect_cpl) exp_q.push_back(model(rid, tag, addr, be, data));
    endtask

    task automatic tick;
        @(posedge pcie_clk);
        #1;
        bar0_rd_valid = 1'b0;
        bar1_rd_valid = 1'b0;
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!s_axis_cc_tvalid && n < 20) begin
            @(negedge pcie_clk);
            n++;
        end
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_q.size() != 0 || s_axis_cc_tvalid) && n < 60) begin
            @(negedge pcie_clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        @(posedge pcie_clk);
        #1;
    endtask

    // Scoreboard: every accepted beat must match the oldest expected completion
    always @(negedge pcie_clk) begin
        if (compl_done || prev_acc) begin
            checks++;
            if (compl_done !== prev_acc) begin
                errors++;
                $display("FAIL compl_done: got %b expected %b", compl_done, prev_acc);
            end
        end
        if (compl_done) done_cnt++;
        prev_acc = s_axis_cc_tvalid && s_axis_cc_tready && pcie_rst_n;
        if (prev_acc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got tdata=%h expected no beat", s_axis_cc_tdata);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (s_axis_cc_tdata !== e || s_axis_cc_tkeep !== 4'hF || s_axis_cc_tlast !== 1'b1 ||
                    s_axis_cc_tuser !== 33'd0) begin
                    errors++;
                    $display("FAIL beat: got tdata=%h keep=%h last=%b user=%h expected tdata=%h keep=f last=1 user=0",
                             s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tuser, e);
                end
            end
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge pcie_clk);
        checks++;
        if ({s_axis_cc_tvalid, s_axis_cc_tlast, s_axis_cc_tkeep, s_axis_cc_tdata, s_axis_cc_tuser,
             compl_done, slot_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b keep=%h tdata=%h done=%b ovf=%b expected all 0",
                     s_axis_cc_tvalid, s_axis_cc_tkeep, s_axis_cc_tdata, compl_done, slot_overflow);
        end
        @(posedge pcie_clk);
        #1;
        pcie_rst_n = 1'b1;
        repeat (3) @(negedge pcie_clk);
        checks++;
        if (s_axis_cc_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got tvalid=%b expected 0", s_axis_cc_tvalid);
        end
    endtask

    task automatic test_bar0_read;
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        set_req(1'b0, 16'h0100, 8'h12, 16'h0024, 8'h0F, 32'hDEADBEEF, 1'b1);
        tick;
        checks++;
        if (s_axis_cc_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_e0: got tvalid=%b expected 0", s_axis_cc_tvalid);
        end
        @(posedge pcie_clk);
        #1;
        checks++;
        if ({s_axis_cc_tvalid, s_axis_cc_tdata[6:0], s_axis_cc_tdata[28:16], s_axis_cc_tdata[42:32],
             s_axis_cc_tdata[63:48], s_axis_cc_tdata[71:64], s_axis_cc_tdata[127:96]} !==
            {1'b1, 7'h24, 13'd4, 11'd1, 16'h0100, 8'h12, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL bar0_fields: got valid=%b tdata=%h expected valid=1 la=24 bc=4 dwc=1 rid=0100 tag=12 data=deadbeef",
                     s_axis_cc_tvalid, s_axis_cc_tdata);
        end
        drain;
    endtask

    task automatic test_be_sweep;
        logic [7:0]  bes [4] = '{8'h06, 8'h08, 8'h09, 8'h00};
        logic [6:0]  las [4] = '{7'h11, 7'h13, 7'h10, 7'h10};
        logic [12:0] bcs [4] = '{13'd2, 13'd1, 13'd4, 13'd1};
        s_axis_cc_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 16'h0200, 8'(8'h20 + i), 16'h0010, bes[i], 32'h1000_0000 + i, 1'b1);
            tick;
            wait_valid;
            checks++;
            if ({s_axis_cc_tvalid, s_axis_cc_tdata[6:0], s_axis_cc_tdata[28:16]} !== {1'b1, las[i], bcs[i]}) begin
                errors++;
                $display("FAIL be_sweep_%h: got valid=%b la=%h bc=%0d expected valid=1 la=%h bc=%0d", bes[i],
                         s_axis_cc_tvalid, s_axis_cc_tdata[6:0], s_axis_cc_tdata[28:16], las[i], bcs[i]);
            end
            drain;
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] held;
        int d0;
        s_axis_cc_tready = 1'b0;
        set_req(1'b1, 16'h0300, 8'h33, 16'h0048, 8'h03, 32'hCAFEF00D, 1'b1);
        tick;
        wait_valid;
        held = s_axis_cc_tdata;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge pcie_clk);
            checks++;
            if (s_axis_cc_tvalid !== 1'b1 || s_axis_cc_tdata !== held) begin
                errors++;
                $display("FAIL hold_%0d: got valid=%b tdata=%h expected valid=1 tdata=%h", i,
                         s_axis_cc_tvalid, s_axis_cc_tdata, held);
            end
        end
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        drain;
        repeat (3) @(negedge pcie_clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        set_req(1'b0, 16'h0400, 8'h01, 16'h0000, 8'h0F, 32'h0000_0A01, 1'b1);
        set_req(1'b1, 16'h0401, 8'h02, 16'h0004, 8'h0F, 32'h0000_0B02, 1'b1);
        tick;
        wait_valid;
        checks++;
        if (s_axis_cc_tdata[71:64] !== 8'h01) begin
            errors++;
            $display("FAIL first_tag: got %h expected 01", s_axis_cc_tdata[71:64]);
        end
        @(negedge pcie_clk);
        checks++;
        if (s_axis_cc_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bubble: got tvalid=%b expected 0", s_axis_cc_tvalid);
        end
        @(negedge pcie_clk);
        checks++;
        if ({s_axis_cc_tvalid, s_axis_cc_tdata[71:64]} !== {1'b1, 8'h02}) begin
            errors++;
            $display("FAIL second_beat: got valid=%b tag=%h expected valid=1 tag=02",
                     s_axis_cc_tvalid, s_axis_cc_tdata[71:64]);
        end
        drain;
        set_req(1'b0, 16'h0400, 8'h03, 16'h0008, 8'h0F, 32'h0000_0A03, 1'b1);
        tick;
        drain;
        set_req(1'b1, 16'h0401, 8'h05, 16'h000C, 8'h0F, 32'h0000_0B05, 1'b1);
        set_req(1'b0, 16'h0400, 8'h04, 16'h0010, 8'h0F, 32'h0000_0A04, 1'b1);
        tick;
        wait_valid;
        checks++;
        if (s_axis_cc_tdata[71:64] !== 8'h05) begin
            errors++;
            $display("FAIL rr_bar1_first: got tag %h expected 05", s_axis_cc_tdata[71:64]);
        end
        drain;
    endtask

    task automatic test_capture_on_clear;
        s_axis_cc_tready = 1'b0;
        set_req(1'b0, 16'h0500, 8'h41, 16'h0014, 8'h0C, 32'h4141_4141, 1'b1);
        tick;
        wait_valid;
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        set_req(1'b0, 16'h0500, 8'h42, 16'h0018, 8'h01, 32'h4242_4242, 1'b1);
        tick;
        drain;
        checks++;
        if (slot_overflow !== 1'b0) begin
            errors++;
            $display("FAIL capture_on_clear_ovf: got %b expected 0", slot_overflow);
        end
    endtask

    task automatic test_overflow;
        s_axis_cc_tready = 1'b0;
        set_req(1'b0, 16'h0600, 8'h0A, 16'h0020, 8'h0F, 32'hAAAA_0001, 1'b1);
        tick;
        wait_valid;
        @(posedge pcie_clk);
        #1;
        set_req(1'b0, 16'h0600, 8'h0B, 16'h0030, 8'h0F, 32'hBBBB_0002, 1'b0);
        tick;
        @(negedge pcie_clk);
        checks++;
        if ({slot_overflow, s_axis_cc_tdata[127:96]} !== {1'b1, 32'hAAAA_0001}) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b data=%h expected ovf=1 data=aaaa0001",
                     slot_overflow, s_axis_cc_tdata[127:96]);
        end
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        drain;
        repeat (5) @(negedge pcie_clk);
        checks++;
        if ({slot_overflow, s_axis_cc_tvalid} !== 2'b10) begin
            errors++;
            $display("FAIL overflow_sticky: got ovf=%b valid=%b expected ovf=1 valid=0",
                     slot_overflow, s_axis_cc_tvalid);
        end
    endtask

    task automatic test_reset_mid_send;
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b0;
        set_req(1'b1, 16'h0700, 8'h55, 16'h0040, 8'h0F, 32'h5555_5555, 1'b1);
        tick;
        wait_valid;
        @(posedge pcie_clk);
        #2;
        pcie_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_axis_cc_tvalid, compl_done, slot_overflow} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got valid=%b done=%b ovf=%b expected all 0",
                     s_axis_cc_tvalid, compl_done, slot_overflow);
        end
        exp_q.delete();
        @(posedge pcie_clk);
        #1;
        pcie_rst_n = 1'b1;
        s_axis_cc_tready = 1'b1;
        repeat (20) @(negedge pcie_clk);
        checks++;
        if ({s_axis_cc_tvalid, slot_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL stale_after_reset: got valid=%b ovf=%b expected 0 0", s_axis_cc_tvalid, slot_overflow);
        end
    endtask

    initial begin
        test_reset;
        test_bar0_read;
        test_be_sweep;
        test_backpressure;
        test_back_to_back;
        test_capture_on_clear;
        test_overflow;
        test_reset_mid_send;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
